// File: rtl/iter_shifter_if.sv
// Request/result handshake bundle for iter_shifter; out_carry exists only when
// ITER_SHIFT_CARRY_EN is defined.
interface iter_shifter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef ITER_SHIFT_CARRY_EN
    logic             out_carry;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );
    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );
`else
    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/iter_shifter.sv
// Iterative 1-bit-per-cycle ROL/SLL/ROR/SRA shifter; out_carry added by ITER_SHIFT_CARRY_EN.
// Latency cnt+1 cycles from accept; result held while out_ready low, no accept while shifting.
module iter_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    iter_shifter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_e           state_q, state_d;
    state_e           start_st;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] stage_dat;
    logic             accept;

    assign accept   = bus.in_valid & bus.in_ready;
    assign start_st = (bus.in_cnt == '0) ? ST_DONE : ST_SHIFT;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; cnt_q==1 in SHIFT marks the final stage
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) state_d = start_st;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = bus.in_valid ? start_st : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_IDLE: bus.in_ready = 1'b1;
            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        stage_dat = data_q;
        case (op_q)
            OP_ROL:  stage_dat = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            OP_SLL:  stage_dat = {data_q[WIDTH-2:0], 1'b0};
            OP_ROR:  stage_dat = {data_q[0], data_q[WIDTH-1:1]};
            OP_SRA:  stage_dat = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            default: stage_dat = data_q;
        endcase
    end

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        if (accept) begin
            data_d = bus.in_data;
            cnt_d  = bus.in_cnt;
            op_d   = bus.in_op;
        end else if (state_q == ST_SHIFT) begin
            data_d = stage_dat;
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
            op_q   <= OP_ROL;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
        end
    end

    assign bus.out_data = data_q;

`ifdef ITER_SHIFT_CARRY_EN
    logic carry_q, carry_d;
    logic stage_out;

    // Left-moving ops lose the MSB, right-moving ops lose the LSB
    assign stage_out = op_q[1] ? data_q[0] : data_q[WIDTH-1];

    always_comb begin
        carry_d = carry_q;
        if (accept) begin
            carry_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            carry_d = stage_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign bus.out_carry = carry_q;
`endif

endmodule
